// File: rtl/axi_addr_router.sv
`default_nettype none
// ============================================================================
// Module   : axi_addr_router
// Brief    : Single-master to NSLV-slave AXI handshake router with error slave.
// Revision : 1.0 - initial release
// ============================================================================
module axi_addr_router #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NSLV           = 2,
    parameter int SLV_POWER_SIZE = 12,
    parameter logic [NSLV*(AXI_ADDR_WIDTH-SLV_POWER_SIZE)-1:0] SLV_BASE = {20'hFEED1, 20'hFEED0}
) (
    input  logic                         CPUNC_ACLK,
    input  logic                         CPUNC_ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0]    CPUNC_AWADDR,
    input  logic [7:0]                   CPUNC_AWID,
    input  logic                         CPUNC_AWVALID,
    output logic                         CPUNC_AWREADY,
    input  logic                         CPUNC_WLAST,
    input  logic                         CPUNC_WVALID,
    output logic                         CPUNC_WREADY,
    output logic [7:0]                   CPUNC_BID,
    output logic                         CPUNC_BRESP,
    output logic                         CPUNC_BVALID,
    input  logic                         CPUNC_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]    CPUNC_ARADDR,
    input  logic [7:0]                   CPUNC_ARID,
    input  logic [7:0]                   CPUNC_ARLN,
    input  logic                         CPUNC_ARVALID,
    output logic                         CPUNC_ARREADY,
    output logic [7:0]                   CPUNC_RID,
    output logic [AXI_DATA_WIDTH-1:0]    CPUNC_RDATA,
    output logic                         CPUNC_RRESP,
    output logic                         CPUNC_RLAST,
    output logic                         CPUNC_RVALID,
    input  logic                         CPUNC_RREADY,
    output logic [NSLV-1:0]              CPUNCS_AWVALID,
    input  logic [NSLV-1:0]              CPUNCS_AWREADY,
    output logic [NSLV-1:0]              CPUNCS_WVALID,
    input  logic [NSLV-1:0]              CPUNCS_WREADY,
    input  logic [NSLV*8-1:0]            CPUNCS_BID,
    input  logic [NSLV-1:0]              CPUNCS_BRESP,
    input  logic [NSLV-1:0]              CPUNCS_BVALID,
    output logic [NSLV-1:0]              CPUNCS_BREADY,
    output logic [NSLV-1:0]              CPUNCS_ARVALID,
    input  logic [NSLV-1:0]              CPUNCS_ARREADY,
    input  logic [NSLV*8-1:0]            CPUNCS_RID,
    input  logic [NSLV*AXI_DATA_WIDTH-1:0] CPUNCS_RDATA,
    input  logic [NSLV-1:0]              CPUNCS_RRESP,
    input  logic [NSLV-1:0]              CPUNCS_RLAST,
    input  logic [NSLV-1:0]              CPUNCS_RVALID,
    output logic [NSLV-1:0]              CPUNCS_RREADY
);

    localparam int TAG_W = AXI_ADDR_WIDTH - SLV_POWER_SIZE;
    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_ERR  = 2'd2
    } rstate_t;

    wstate_t             wstate_q, wstate_d;
    logic [SEL_W-1:0]    wsel_q, wsel_d;
    logic                werr_q, werr_d;
    logic [7:0]          wid_q, wid_d;

    rstate_t             rstate_q, rstate_d;
    logic [SEL_W-1:0]    rsel_q, rsel_d;
    logic                rerr_q, rerr_d;
    logic [7:0]          rid_q, rid_d;
    logic [7:0]          rcnt_q, rcnt_d;

    logic [SEL_W-1:0]    w_aw_sel, w_ar_sel;
    logic                w_aw_hit, w_ar_hit;
    logic                w_awready, w_wready, w_bvalid;
    logic                w_arready, w_rvalid, w_rlast;

    // Only the window tag bits take part in decoding.
    logic w_unused;
    assign w_unused = ^{CPUNC_AWADDR[SLV_POWER_SIZE-1:0], CPUNC_ARADDR[SLV_POWER_SIZE-1:0]};

    // Descending scan so that the lowest matching index is the one that sticks.
    always_comb begin
        w_aw_sel = '0;
        w_aw_hit = 1'b0;
        w_ar_sel = '0;
        w_ar_hit = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (CPUNC_AWADDR[AXI_ADDR_WIDTH-1:SLV_POWER_SIZE] == SLV_BASE[i*TAG_W +: TAG_W]) begin
                w_aw_hit = 1'b1;
                w_aw_sel = SEL_W'(i);
            end
            if (CPUNC_ARADDR[AXI_ADDR_WIDTH-1:SLV_POWER_SIZE] == SLV_BASE[i*TAG_W +: TAG_W]) begin
                w_ar_hit = 1'b1;
                w_ar_sel = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge CPUNC_ACLK) begin
        if (CPUNC_ARESET) begin
            wstate_q <= W_IDLE;
            wsel_q   <= '0;
            werr_q   <= 1'b0;
            wid_q    <= '0;
            rstate_q <= R_IDLE;
            rsel_q   <= '0;
            rerr_q   <= 1'b0;
            rid_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            wsel_q   <= wsel_d;
            werr_q   <= werr_d;
            wid_q    <= wid_d;
            rstate_q <= rstate_d;
            rsel_q   <= rsel_d;
            rerr_q   <= rerr_d;
            rid_q    <= rid_d;
            rcnt_q   <= rcnt_d;
        end
    end

    // Write path; everything is forced quiet while reset is held.
    always_comb begin
        wstate_d       = wstate_q;
        wsel_d         = wsel_q;
        werr_d         = werr_q;
        wid_d          = wid_q;
        w_awready      = 1'b0;
        w_wready       = 1'b0;
        w_bvalid       = 1'b0;
        CPUNC_BID      = '0;
        CPUNC_BRESP    = 1'b0;
        CPUNCS_AWVALID = '0;
        CPUNCS_WVALID  = '0;
        CPUNCS_BREADY  = '0;
        if (!CPUNC_ARESET) begin
            case (wstate_q)
                W_IDLE: begin
                    if (w_aw_hit) begin
                        for (int i = 0; i < NSLV; i++) begin
                            if (w_aw_sel == SEL_W'(i)) begin
                                CPUNCS_AWVALID[i] = CPUNC_AWVALID;
                                w_awready         = CPUNCS_AWREADY[i];
                            end
                        end
                    end else begin
                        w_awready = 1'b1;
                    end
                    if (CPUNC_AWVALID && w_awready) begin
                        wsel_d   = w_aw_sel;
                        werr_d   = !w_aw_hit;
                        wid_d    = CPUNC_AWID;
                        wstate_d = W_DATA;
                    end
                end
                W_DATA: begin
                    if (werr_q) begin
                        w_wready = 1'b1;
                    end else begin
                        for (int i = 0; i < NSLV; i++) begin
                            if (wsel_q == SEL_W'(i)) begin
                                CPUNCS_WVALID[i] = CPUNC_WVALID;
                                w_wready         = CPUNCS_WREADY[i];
                            end
                        end
                    end
                    if (CPUNC_WVALID && w_wready && CPUNC_WLAST) begin
                        wstate_d = W_RESP;
                    end
                end
                W_RESP: begin
                    if (werr_q) begin
                        w_bvalid    = 1'b1;
                        CPUNC_BRESP = 1'b1;
                        CPUNC_BID   = wid_q;
                    end else begin
                        for (int i = 0; i < NSLV; i++) begin
                            if (wsel_q == SEL_W'(i)) begin
                                w_bvalid         = CPUNCS_BVALID[i];
                                CPUNC_BRESP      = CPUNCS_BRESP[i];
                                CPUNC_BID        = CPUNCS_BID[i*8 +: 8];
                                CPUNCS_BREADY[i] = CPUNC_BREADY;
                            end
                        end
                    end
                    if (w_bvalid && CPUNC_BREADY) begin
                        wstate_d = W_IDLE;
                    end
                end
                default: wstate_d = W_IDLE;
            endcase
        end
    end

    always_comb begin
        rstate_d       = rstate_q;
        rsel_d         = rsel_q;
        rerr_d         = rerr_q;
        rid_d          = rid_q;
        rcnt_d         = rcnt_q;
        w_arready      = 1'b0;
        w_rvalid       = 1'b0;
        w_rlast        = 1'b0;
        CPUNC_RID      = '0;
        CPUNC_RDATA    = '0;
        CPUNC_RRESP    = 1'b0;
        CPUNCS_ARVALID = '0;
        CPUNCS_RREADY  = '0;
        if (!CPUNC_ARESET) begin
            case (rstate_q)
                R_IDLE: begin
                    if (w_ar_hit) begin
                        for (int i = 0; i < NSLV; i++) begin
                            if (w_ar_sel == SEL_W'(i)) begin
                                CPUNCS_ARVALID[i] = CPUNC_ARVALID;
                                w_arready         = CPUNCS_ARREADY[i];
                            end
                        end
                    end else begin
                        w_arready = 1'b1;
                    end
                    if (CPUNC_ARVALID && w_arready) begin
                        rsel_d   = w_ar_sel;
                        rerr_d   = !w_ar_hit;
                        rid_d    = CPUNC_ARID;
                        rcnt_d   = CPUNC_ARLN;
                        rstate_d = w_ar_hit ? R_DATA : R_ERR;
                    end
                end
                R_DATA: begin
                    for (int i = 0; i < NSLV; i++) begin
                        if (rsel_q == SEL_W'(i)) begin
                            w_rvalid         = CPUNCS_RVALID[i];
                            w_rlast          = CPUNCS_RLAST[i];
                            CPUNC_RRESP      = CPUNCS_RRESP[i];
                            CPUNC_RID        = CPUNCS_RID[i*8 +: 8];
                            CPUNC_RDATA      = CPUNCS_RDATA[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                            CPUNCS_RREADY[i] = CPUNC_RREADY;
                        end
                    end
                    if (w_rvalid && CPUNC_RREADY && w_rlast) begin
                        rstate_d = R_IDLE;
                    end
                end
                R_ERR: begin
                    // Synthesised error burst: ARLN+1 zero-data beats.
                    w_rvalid    = 1'b1;
                    CPUNC_RRESP = 1'b1;
                    CPUNC_RID   = rid_q;
                    w_rlast     = (rcnt_q == 8'd0);
                    if (CPUNC_RREADY) begin
                        if (rcnt_q == 8'd0) begin
                            rstate_d = R_IDLE;
                        end else begin
                            rcnt_d = rcnt_q - 8'd1;
                        end
                    end
                end
                default: rstate_d = R_IDLE;
            endcase
        end
    end

    assign CPUNC_AWREADY = w_awready;
    assign CPUNC_WREADY  = w_wready;
    assign CPUNC_BVALID  = w_bvalid;
    assign CPUNC_ARREADY = w_arready;
    assign CPUNC_RVALID  = w_rvalid;
    assign CPUNC_RLAST   = w_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_addr_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_addr_router
// Brief    : Directed self-checking bench for axi_addr_router (2 slaves).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_addr_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, araddr, wdata, mem0;
    logic [7:0]  awid, arid, arln;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready, wready, bresp, bvalid, arready, rresp, rlast, rvalid;
    logic [7:0]  bid, rid;
    logic [31:0] rdata;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rresp, s_rlast, s_rvalid, s_rready;
    logic [15:0] s_bid, s_rid;
    logic [63:0] s_rdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    axi_addr_router dut (
        .CPUNC_ACLK(clk),          .CPUNC_ARESET(rst),
        .CPUNC_AWADDR(awaddr),     .CPUNC_AWID(awid),
        .CPUNC_AWVALID(awvalid),   .CPUNC_AWREADY(awready),
        .CPUNC_WLAST(wlast),       .CPUNC_WVALID(wvalid),     .CPUNC_WREADY(wready),
        .CPUNC_BID(bid),           .CPUNC_BRESP(bresp),
        .CPUNC_BVALID(bvalid),     .CPUNC_BREADY(bready),
        .CPUNC_ARADDR(araddr),     .CPUNC_ARID(arid),         .CPUNC_ARLN(arln),
        .CPUNC_ARVALID(arvalid),   .CPUNC_ARREADY(arready),
        .CPUNC_RID(rid),           .CPUNC_RDATA(rdata),       .CPUNC_RRESP(rresp),
        .CPUNC_RLAST(rlast),       .CPUNC_RVALID(rvalid),     .CPUNC_RREADY(rready),
        .CPUNCS_AWVALID(s_awvalid), .CPUNCS_AWREADY(s_awready),
        .CPUNCS_WVALID(s_wvalid),   .CPUNCS_WREADY(s_wready),
        .CPUNCS_BID(s_bid),         .CPUNCS_BRESP(s_bresp),
        .CPUNCS_BVALID(s_bvalid),   .CPUNCS_BREADY(s_bready),
        .CPUNCS_ARVALID(s_arvalid), .CPUNCS_ARREADY(s_arready),
        .CPUNCS_RID(s_rid),         .CPUNCS_RDATA(s_rdata),
        .CPUNCS_RRESP(s_rresp),     .CPUNCS_RLAST(s_rlast),
        .CPUNCS_RVALID(s_rvalid),   .CPUNCS_RREADY(s_rready)
    );

    task automatic idle_all();
        awaddr = '0; awid = '0; awvalid = 0; wlast = 0; wvalid = 0; bready = 0;
        araddr = '0; arid = '0; arln = '0; arvalid = 0; rready = 0; wdata = '0;
        s_awready = '0; s_wready = '0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
        s_arready = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; idle_all();
        s_rvalid = 2'b11; s_bvalid = 2'b11; awvalid = 1; arvalid = 1;
        #1;
        checks++; if ({awready, arready, wready} !== 3'b000) begin failures++; $display("FAIL rst_ready: got %b want 000", {awready, arready, wready}); end
        checks++; if ({bvalid, rvalid, rlast, bresp, rresp} !== 5'b0) begin failures++; $display("FAIL rst_resp: got %b want 00000", {bvalid, rvalid, rlast, bresp, rresp}); end
        checks++; if ({bid, rid, rdata} !== 48'h0) begin failures++; $display("FAIL rst_payload: got %h want 0", {bid, rid, rdata}); end
        checks++; if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 10'b0) begin failures++; $display("FAIL rst_slv: got %b want 0", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}); end
        @(negedge clk);
        rst = 0; idle_all();
        #1;
        checks++; if ({bvalid, rvalid, bid, rid} !== 18'h0) begin failures++; $display("FAIL post_rst_idle: got %h want 0", {bvalid, rvalid, bid, rid}); end
    endtask

    task automatic test_write_s0();
        @(negedge clk);
        awaddr = 32'hFEED0010; awid = 8'h3A; awvalid = 1; s_awready = 2'b00;
        #1;
        checks++; if (s_awvalid !== 2'b01) begin failures++; $display("FAIL w0_awvalid_route: got %b want 01", s_awvalid); end
        checks++; if (awready !== 1'b0) begin failures++; $display("FAIL w0_aw_stall: got %b want 0", awready); end
        @(negedge clk);
        s_awready = 2'b01;
        #1;
        checks++; if (awready !== 1'b1) begin failures++; $display("FAIL w0_awready: got %b want 1", awready); end
        @(negedge clk);
        awvalid = 0; s_awready = 0;
        wvalid = 1; wlast = 1; wdata = 32'hA5A5A5A5; s_wready = 2'b01;
        #1;
        checks++; if ({s_wvalid, wready} !== 3'b011) begin failures++; $display("FAIL w0_w_route: got %b want 011", {s_wvalid, wready}); end
        if (s_wvalid[0] && wready) mem0 = wdata;
        @(negedge clk);
        wvalid = 0; wlast = 0; s_wready = 0;
        s_bvalid = 2'b01; s_bid = {8'h00, 8'h3A}; s_bresp = 2'b00; bready = 1;
        #1;
        checks++; if ({bvalid, bresp, bid} !== {1'b1, 1'b0, 8'h3A}) begin failures++; $display("FAIL w0_b: got %h want %h", {bvalid, bresp, bid}, {1'b1, 1'b0, 8'h3A}); end
        checks++; if (s_bready !== 2'b01) begin failures++; $display("FAIL w0_bready_route: got %b want 01", s_bready); end
        @(negedge clk);
        s_bvalid = 0; bready = 0;
        araddr = 32'hFEED0010; arid = 8'h21; arln = 0; arvalid = 1; s_arready = 2'b01;
        #1;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL w0_b_done: got %b want 0", bvalid); end
        checks++; if ({s_arvalid, arready} !== 3'b011) begin failures++; $display("FAIL r0_ar: got %b want 011", {s_arvalid, arready}); end
        @(negedge clk);
        arvalid = 0; s_arready = 0;
        s_rvalid = 2'b01; s_rdata = {32'h0, mem0}; s_rid = {8'h00, 8'h21}; s_rlast = 2'b01; s_rresp = 0; rready = 1;
        #1;
        checks++; if (rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL r0_rdata: got %h want a5a5a5a5", rdata); end
        checks++; if ({rvalid, rresp, rlast, rid, s_rready} !== {3'b101, 8'h21, 2'b01}) begin failures++; $display("FAIL r0_rctl: got %h want %h", {rvalid, rresp, rlast, rid, s_rready}, {3'b101, 8'h21, 2'b01}); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_read_burst_s1();
        @(negedge clk);
        araddr = 32'hFEED1004; arid = 8'h47; arln = 8'd3; arvalid = 1; s_arready = 2'b10;
        #1;
        checks++; if ({s_arvalid, arready} !== 3'b101) begin failures++; $display("FAIL r1_ar: got %b want 101", {s_arvalid, arready}); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            arvalid = 0; s_arready = 0; rready = 1;
            s_rvalid = 2'b10; s_rid = {8'h47, 8'h00}; s_rdata = {32'h1000 + b, 32'h0};
            s_rlast = (b == 3) ? 2'b10 : 2'b00;
            #1;
            checks++; if (rdata !== 32'h1000 + b) begin failures++; $display("FAIL r1_rdata beat %0d: got %h want %h", b, rdata, 32'h1000 + b); end
            checks++; if ({rvalid, rlast, rid, s_rready} !== {1'b1, (b == 3), 8'h47, 2'b10}) begin failures++; $display("FAIL r1_rctl beat %0d: got %h want %h", b, {rvalid, rlast, rid, s_rready}, {1'b1, (b == 3), 8'h47, 2'b10}); end
        end
        @(negedge clk);
        idle_all();
        araddr = 32'hFEED1000; arvalid = 1; s_rvalid = 2'b10;
        #1;
        checks++; if ({rvalid, s_arvalid} !== 3'b010) begin failures++; $display("FAIL r1_back_idle: got %b want 010", {rvalid, s_arvalid}); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_read_unmapped();
        @(negedge clk);
        araddr = 32'h12345000; arln = 8'd2; arid = 8'h5C; arvalid = 1; s_arready = 2'b11;
        #1;
        checks++; if ({arready, s_arvalid} !== 3'b100) begin failures++; $display("FAIL rerr_ar: got %b want 100", {arready, s_arvalid}); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            arvalid = 0; rready = 1; s_rvalid = 2'b11; s_rdata = {64{1'b1}};
            #1;
            checks++; if ({rvalid, rresp, rlast, rid, rdata} !== {1'b1, 1'b1, (b == 2), 8'h5C, 32'h0}) begin failures++; $display("FAIL rerr_beat %0d: got %h want %h", b, {rvalid, rresp, rlast, rid, rdata}, {1'b1, 1'b1, (b == 2), 8'h5C, 32'h0}); end
            checks++; if (s_rready !== 2'b00) begin failures++; $display("FAIL rerr_rready beat %0d: got %b want 00", b, s_rready); end
        end
        @(negedge clk);
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rerr_done: got %b want 0", rvalid); end
        idle_all();
    endtask

    task automatic test_write_unmapped();
        @(negedge clk);
        awaddr = 32'h0; awid = 8'h11; awvalid = 1; s_awready = 2'b11;
        #1;
        checks++; if ({awready, s_awvalid} !== 3'b100) begin failures++; $display("FAIL werr_aw: got %b want 100", {awready, s_awvalid}); end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            awvalid = 0; wvalid = 1; wlast = (b == 1); s_wready = 2'b11;
            #1;
            checks++; if ({wready, s_wvalid, bvalid} !== 4'b1000) begin failures++; $display("FAIL werr_w beat %0d: got %b want 1000", b, {wready, s_wvalid, bvalid}); end
        end
        @(negedge clk);
        wvalid = 0; wlast = 0; bready = 0; s_bvalid = 2'b11; s_bresp = 2'b00;
        #1;
        checks++; if ({bvalid, bresp, bid, s_bready} !== {2'b11, 8'h11, 2'b00}) begin failures++; $display("FAIL werr_b_stall: got %h want %h", {bvalid, bresp, bid, s_bready}, {2'b11, 8'h11, 2'b00}); end
        @(negedge clk);
        bready = 1;
        #1;
        checks++; if ({bvalid, bid} !== {1'b1, 8'h11}) begin failures++; $display("FAIL werr_b: got %h want %h", {bvalid, bid}, {1'b1, 8'h11}); end
        @(negedge clk);
        bready = 0;
        #1;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL werr_single_b: got %b want 0", bvalid); end
        idle_all();
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        awaddr = 32'hFEED0020; awid = 8'h61; awvalid = 1; s_awready = 2'b01;
        araddr = 32'hFEED1008; arid = 8'h62; arln = 8'd1; arvalid = 1; s_arready = 2'b10;
        #1;
        checks++; if ({s_awvalid, s_arvalid, awready, arready} !== 6'b011011) begin failures++; $display("FAIL cc_addr: got %b want 011011", {s_awvalid, s_arvalid, awready, arready}); end
        @(negedge clk);
        awvalid = 0; arvalid = 0; s_awready = 0; s_arready = 0;
        wvalid = 1; wlast = 1; s_wready = 2'b01;
        s_rvalid = 2'b10; s_rid = {8'h62, 8'h00}; s_rdata = {32'hDEAD0000, 32'h0}; s_rlast = 2'b00; rready = 0;
        #1;
        checks++; if ({rvalid, rdata, wready, s_rready} !== {1'b1, 32'hDEAD0000, 1'b1, 2'b00}) begin failures++; $display("FAIL cc_stall: got %h want %h", {rvalid, rdata, wready, s_rready}, {1'b1, 32'hDEAD0000, 1'b1, 2'b00}); end
        @(negedge clk);
        wvalid = 0; wlast = 0; s_wready = 0;
        s_bvalid = 2'b01; s_bid = {8'h00, 8'h61}; bready = 1; rready = 1;
        #1;
        checks++; if ({rdata, rid, bvalid, bid} !== {32'hDEAD0000, 8'h62, 1'b1, 8'h61}) begin failures++; $display("FAIL cc_b_r0: got %h want %h", {rdata, rid, bvalid, bid}, {32'hDEAD0000, 8'h62, 1'b1, 8'h61}); end
        @(negedge clk);
        bready = 0; s_bvalid = 0;
        s_rdata = {32'hDEAD0001, 32'h0}; s_rlast = 2'b10; rready = 0;
        #1;
        checks++; if ({rlast, bvalid, s_rready} !== 4'b1000) begin failures++; $display("FAIL cc_r1_stall: got %b want 1000", {rlast, bvalid, s_rready}); end
        @(negedge clk);
        rready = 1;
        #1;
        checks++; if ({rdata, rid} !== {32'hDEAD0001, 8'h62}) begin failures++; $display("FAIL cc_r1: got %h want %h", {rdata, rid}, {32'hDEAD0001, 8'h62}); end
        @(negedge clk);
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL cc_r_done: got %b want 0", rvalid); end
        idle_all();
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        araddr = 32'hFEED1000; arid = 8'h33; arln = 8'd3; arvalid = 1; s_arready = 2'b10;
        @(negedge clk);
        arvalid = 0; s_arready = 0;
        s_rvalid = 2'b10; s_rid = {8'h33, 8'h00}; s_rdata = {32'hBEEF0000, 32'h0}; rready = 1;
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if ({rvalid, rdata, rid, s_rready} !== 43'h0) begin failures++; $display("FAIL mid_rst_out: got %h want 0", {rvalid, rdata, rid, s_rready}); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if ({rvalid, s_rready} !== 3'b000) begin failures++; $display("FAIL mid_rst_idle: got %b want 000", {rvalid, s_rready}); end
        @(negedge clk);
        idle_all();
        araddr = 32'hFEED1000; arid = 8'h77; arln = 8'd0; arvalid = 1; s_arready = 2'b10;
        #1;
        checks++; if (arready !== 1'b1) begin failures++; $display("FAIL fresh_ar: got %b want 1", arready); end
        @(negedge clk);
        arvalid = 0; s_arready = 0;
        s_rvalid = 2'b10; s_rid = {8'h77, 8'h00}; s_rdata = {32'h0000CAFE, 32'h0}; s_rlast = 2'b10; rready = 1;
        #1;
        checks++; if ({rvalid, rlast, rid, rdata} !== {2'b11, 8'h77, 32'h0000CAFE}) begin failures++; $display("FAIL fresh_r: got %h want %h", {rvalid, rlast, rid, rdata}, {2'b11, 8'h77, 32'h0000CAFE}); end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        rst = 1;
        mem0 = '0;
        idle_all();
        repeat (2) @(posedge clk);
        test_reset();
        test_write_s0();
        test_read_burst_s1();
        test_read_unmapped();
        test_write_unmapped();
        test_concurrent();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
